expr_eval: RTL and testbench

- Downstream companion to the expression-string recognizer; consumes the same one-character-per-clock ASCII stream.
- Grammar:
  - operand = single decimal digit '0'..'9', or '(' digit {op digit} ')'.
  - op = '+' or '*'.
  - expression = operand {op operand}.
  - One parenthesis level only.
- Tracks syntax itself and computes the numeric value of the prefix received so far, with '*' binding tighter than '+'.
- Presents a registered value plus a valid flag whenever the prefix is a complete expression; feeds the result display/compare stage.

---
 rtl/expr_eval_if.sv | 20 ++
 rtl/expr_eval.sv | 138 +++++++++++++
 tb/tb_expr_eval.sv | 134 +++++++++++++
 3 files changed

// File: rtl/expr_eval_if.sv
// expr_eval_if: character stream in, evaluated result out.
//   in          ASCII character
//   in_valid    character strobe
//   value       value of the current complete expression
//   value_valid prefix so far is a complete legal expression
//   error       sticky syntax error
//   overflow    sticky arithmetic overflow
interface expr_eval_if #(parameter int WIDTH = 32) ();
    logic [7:0]       in;
    logic             in_valid;
    logic [WIDTH-1:0] value;
    logic             value_valid;
    logic             error;
    logic             overflow;

    modport master (output in, in_valid,
                    input  value, value_valid, error, overflow);
    modport slave  (input  in, in_valid,
                    output value, value_valid, error, overflow);
endinterface

// File: rtl/expr_eval.sv
// expr_eval: one-character-per-clock evaluator for expressions of single
// digits, '+', '*' and one level of parentheses. '*' binds tighter than '+'.
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-low reset
//   bus  expr_eval_if.slave (in/in_valid in; value/value_valid/error/overflow out)
// All outputs are registered and reflect the character accepted on the
// previous edge.
module expr_eval #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        clr,
    expr_eval_if.slave  bus
);
    typedef enum logic [2:0] {START, NUM, OP, LP, INUM, IOP, ERR} state_t;
    typedef logic [2*WIDTH-1:0] wide_t;

    state_t           state, nxt_state;
    logic [WIDTH-1:0] acc_s, acc_p, in_s, in_p, value;
    logic [WIDTH-1:0] nxt_acc_s, nxt_acc_p, nxt_in_s, nxt_in_p, nxt_value;
    logic             vv, err, ovf, nxt_vv, nxt_err, nxt_ovf;

    logic             is_digit;
    logic [WIDTH-1:0] dig;
    wide_t            prod_p, prod_ip, sum_s, sum_is, prod_v, vsum;

    assign is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    assign dig      = WIDTH'(bus.in[3:0]);

    // Every candidate operation is evaluated at double width; the upper half
    // is the overflow indication for whichever one the FSM actually uses.
    assign prod_p  = wide_t'(acc_p) * wide_t'(dig);
    assign prod_ip = wide_t'(in_p)  * wide_t'(dig);
    assign sum_s   = wide_t'(acc_s) + wide_t'(acc_p);
    assign sum_is  = wide_t'(in_s)  + wide_t'(in_p);
    assign prod_v  = wide_t'(acc_p) * wide_t'(sum_is[WIDTH-1:0]);
    assign vsum    = wide_t'(acc_s) + wide_t'(nxt_acc_p);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= START;
            acc_s <= '0;
            acc_p <= WIDTH'(1);
            in_s  <= '0;
            in_p  <= WIDTH'(1);
            value <= '0;
            vv    <= 1'b0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= nxt_state;
            acc_s <= nxt_acc_s;
            acc_p <= nxt_acc_p;
            in_s  <= nxt_in_s;
            in_p  <= nxt_in_p;
            value <= nxt_value;
            vv    <= nxt_vv;
            err   <= nxt_err;
            ovf   <= nxt_ovf;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_acc_s = acc_s;
        nxt_acc_p = acc_p;
        nxt_in_s  = in_s;
        nxt_in_p  = in_p;
        nxt_value = value;
        nxt_vv    = vv;
        nxt_err   = err;
        nxt_ovf   = ovf;
        if (bus.in_valid) begin
            nxt_state = ERR;   // anything not matched below is a syntax error
            case (state)
                START, OP: begin
                    if (is_digit) begin
                        nxt_state = NUM;
                        nxt_acc_p = prod_p[WIDTH-1:0];
                        nxt_ovf   = nxt_ovf | (|prod_p[2*WIDTH-1:WIDTH]);
                    end else if (bus.in == 8'h28) begin
                        nxt_state = LP;
                        nxt_in_s  = '0;
                        nxt_in_p  = WIDTH'(1);
                    end
                end
                NUM: begin
                    if (bus.in == 8'h2b) begin
                        nxt_state = OP;
                        nxt_acc_s = sum_s[WIDTH-1:0];
                        nxt_acc_p = WIDTH'(1);
                        nxt_ovf   = nxt_ovf | (|sum_s[2*WIDTH-1:WIDTH]);
                    end else if (bus.in == 8'h2a) begin
                        nxt_state = OP;
                    end
                end
                LP, IOP: begin
                    if (is_digit) begin
                        nxt_state = INUM;
                        nxt_in_p  = prod_ip[WIDTH-1:0];
                        nxt_ovf   = nxt_ovf | (|prod_ip[2*WIDTH-1:WIDTH]);
                    end
                end
                INUM: begin
                    if (bus.in == 8'h2b) begin
                        nxt_state = IOP;
                        nxt_in_s  = sum_is[WIDTH-1:0];
                        nxt_in_p  = WIDTH'(1);
                        nxt_ovf   = nxt_ovf | (|sum_is[2*WIDTH-1:WIDTH]);
                    end else if (bus.in == 8'h2a) begin
                        nxt_state = IOP;
                    end else if (bus.in == 8'h29) begin
                        // Closing paren folds the bracketed sum into the
                        // outer product as a single operand.
                        nxt_state = NUM;
                        nxt_acc_p = prod_v[WIDTH-1:0];
                        nxt_ovf   = nxt_ovf | (|sum_is[2*WIDTH-1:WIDTH])
                                            | (|prod_v[2*WIDTH-1:WIDTH]);
                    end
                end
                default: nxt_state = ERR;
            endcase
            nxt_vv = (nxt_state == NUM);
            if (nxt_state == NUM) begin
                nxt_value = vsum[WIDTH-1:0];
                nxt_ovf   = nxt_ovf | (|vsum[2*WIDTH-1:WIDTH]);
            end
            if (nxt_state == ERR)
                nxt_err = 1'b1;
        end
    end

    assign bus.value       = value;
    assign bus.value_valid = vv;
    assign bus.error       = err;
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: directed vectors against a 32-bit and an 8-bit instance
// driven with the same character stream.
module tb_expr_eval;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    expr_eval_if #(.WIDTH(32)) b32 ();
    expr_eval_if #(.WIDTH(8))  b8  ();

    expr_eval #(.WIDTH(32)) dut   (.clk(clk), .clr(clr), .bus(b32.slave));
    expr_eval #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(b8.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input byte c);
        @(negedge clk);
        b32.in = c; b8.in = c;
        b32.in_valid = 1'b1; b8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0; b8.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    // Stream a string, checking value_valid / value after every character.
    task automatic run(input string tag, input string s,
                       input logic [31:0] vv_exp[], input logic [31:0] val_exp[]);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            chk($sformatf("%s vv[%0d]", tag, i),  64'(b32.value_valid), 64'(vv_exp[i]));
            chk($sformatf("%s val[%0d]", tag, i), 64'(b32.value),       64'(val_exp[i]));
        end
    endtask

    initial begin
        b32.in = 8'h0; b8.in = 8'h0;
        b32.in_valid = 1'b0; b8.in_valid = 1'b0;
        #12;
        chk("rst value", 64'(b32.value), 0);
        chk("rst vv",    64'(b32.value_valid), 0);
        chk("rst err",   64'(b32.error), 0);
        chk("rst ovf",   64'(b32.overflow), 0);
        clr = 1'b1;

        run("t1", "1+2*3", '{1,0,1,0,1}, '{1,1,3,3,7});
        chk("t1 err", 64'(b32.error), 0);

        do_reset();
        run("t2", "2*(3+4)", '{1,0,0,0,0,0,1}, '{2,2,2,2,2,2,14});

        do_reset();
        run("t3", "1++5", '{1,0,0,0}, '{1,1,1,1});
        chk("t3 err", 64'(b32.error), 1);

        do_reset();
        run("t4", "9*9*9", '{1,0,1,0,1}, '{9,9,81,81,729});
        chk("t4 ovf32", 64'(b32.overflow), 0);
        chk("t4 val8",  64'(b8.value), 217);
        chk("t4 ovf8",  64'(b8.overflow), 1);
        chk("t4 vv8",   64'(b8.value_valid), 1);
        chk("t4 err8",  64'(b8.error), 0);

        // Final add overflows only in the value sum on the 8-bit instance.
        do_reset();
        run("t4b", "9*9*3+9*2", '{1,0,1,0,1,0,1,0,1}, '{9,9,81,81,243,243,252,252,261});
        chk("t4b val8", 64'(b8.value), 5);
        chk("t4b ovf8", 64'(b8.overflow), 1);

        // Gapped stream: outputs must hold across idle cycles.
        do_reset();
        begin
            string s = "(9*9)";
            for (int i = 0; i < s.len(); i++) begin
                logic [7:0] v0; logic vv0;
                send(s[i]);
                v0 = b32.value; vv0 = b32.value_valid;
                chk($sformatf("t5 vv[%0d]", i), 64'(vv0), (i == 4) ? 1 : 0);
                chk($sformatf("t5 val[%0d]", i), 64'(b32.value), (i == 4) ? 81 : 0);
                repeat (3) @(posedge clk);
                #1;
                chk($sformatf("t5 hold vv[%0d]", i),  64'(b32.value_valid), 64'(vv0));
                chk($sformatf("t5 hold val[%0d]", i), 64'(b32.value), 64'(v0));
            end
        end

        // Boundary errors.
        do_reset(); run("t6a", "((", '{0,0}, '{0,0});
        chk("t6a err", 64'(b32.error), 1);
        do_reset(); run("t6b", "3)", '{1,0}, '{3,3});
        chk("t6b err", 64'(b32.error), 1);
        do_reset(); run("t6c", "34", '{1,0}, '{3,3});
        chk("t6c err", 64'(b32.error), 1);
        do_reset(); run("t6d", "(1)2", '{0,0,1,0}, '{0,0,1,1});
        chk("t6d err", 64'(b32.error), 1);
        do_reset(); run("t6e", "5*0", '{1,0,1}, '{5,5,0});
        chk("t6e err", 64'(b32.error), 0);

        // Asynchronous clear mid-expression.
        do_reset();
        run("t7", "3*(", '{1,0,0}, '{3,3,3});
        #2 clr = 1'b0;
        #1;
        chk("t7 rst val", 64'(b32.value), 0);
        chk("t7 rst vv",  64'(b32.value_valid), 0);
        chk("t7 rst err", 64'(b32.error), 0);
        chk("t7 rst ovf", 64'(b32.overflow), 0);
        @(posedge clk);
        @(negedge clk) clr = 1'b1;
        send("4");
        chk("t7 val", 64'(b32.value), 4);
        chk("t7 vv",  64'(b32.value_valid), 1);
        chk("t7 err", 64'(b32.error), 0);
        chk("t7 ovf", 64'(b32.overflow), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
